// File: rtl/factor_judge_if.sv
// Game-control handshake bundle between the game controller and the factor judge.
// Controller side drives STATE/QUESTION/SEL/DEC/CLR; responder returns judgement,
// wrong-attempt, HP status codes plus remainder and both HP counters for display.
interface factor_judge_if #(
  parameter int QW = 8
);
  logic [3:0]    STATE;
  logic [QW-1:0] QUESTION;
  logic [2:0]    SEL;
  logic          DEC;
  logic          CLR;
  logic [1:0]    JUDG_OUT;
  logic [1:0]    WRONG_OUT;
  logic [1:0]    HP_OUT;
  logic [QW-1:0] REMAIN;
  logic [2:0]    P_HP;
  logic [2:0]    C_HP;

  modport master (
    output STATE, QUESTION, SEL, DEC, CLR,
    input  JUDG_OUT, WRONG_OUT, HP_OUT, REMAIN, P_HP, C_HP
  );

  modport slave (
    input  STATE, QUESTION, SEL, DEC, CLR,
    output JUDG_OUT, WRONG_OUT, HP_OUT, REMAIN, P_HP, C_HP
  );
endinterface

// File: rtl/factor_judge.sv
// Responder for the factoring game: holds the question remainder, divides it by the
// selected prime on each DEC rising edge, runs the answer timer and tracks both HPs.
// Ports: CLK, RST (sync, active-high), bus (factor_judge_if.slave). All outputs registered, 1 cycle.
module factor_judge #(
  parameter int QW         = 8,
  parameter int TIME_LIMIT = 250_000_000,
  parameter int HP_INIT    = 3
) (
  input logic           CLK,
  input logic           RST,
  factor_judge_if.slave bus
);

  typedef enum logic [3:0] {
    ST_READY    = 4'b0010,
    ST_QUESTION = 4'b0011,
    ST_INPUT    = 4'b0100,
    ST_DRAW     = 4'b0110,
    ST_WRONG    = 4'b0111,
    ST_GOOD     = 4'b1000,
    ST_OUCH     = 4'b1001,
    ST_WIN      = 4'b1010,
    ST_LOSE     = 4'b1011
  } ctrl_state_e;

  localparam int TW = $clog2(TIME_LIMIT + 1);
  localparam logic [TW-1:0] TLIM   = TW'(TIME_LIMIT);
  localparam logic [2:0]    HP_RST = 3'(HP_INIT);

  logic [3:0]    state_q;
  logic          dec_q, clr_q;
  logic [QW-1:0] remain_q, remain_d;
  logic [QW-1:0] q_latch_q, q_latch_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    judg_q, judg_d;
  logic [1:0]    wrong_q, wrong_d;
  logic [1:0]    hp_out_q, hp_out_d;
  logic [2:0]    p_hp_q, p_hp_d;
  logic [2:0]    c_hp_q, c_hp_d;

  logic          dec_edge, clr_edge, entered, expire;
  logic [QW:0]   div_res;

  // Constant-divisor quotient per prime; MSB flags an exact division.
  function automatic logic [QW:0] div_prime(input logic [QW-1:0] v, input logic [2:0] s);
    logic [QW-1:0] q, r;
    case (s)
      3'd0:    begin q = v / QW'(2);  r = v % QW'(2);  end
      3'd1:    begin q = v / QW'(3);  r = v % QW'(3);  end
      3'd2:    begin q = v / QW'(5);  r = v % QW'(5);  end
      3'd3:    begin q = v / QW'(7);  r = v % QW'(7);  end
      3'd4:    begin q = v / QW'(11); r = v % QW'(11); end
      3'd5:    begin q = v / QW'(13); r = v % QW'(13); end
      3'd6:    begin q = v / QW'(17); r = v % QW'(17); end
      default: begin q = v / QW'(19); r = v % QW'(19); end
    endcase
    return {(r == '0), q};
  endfunction

  always_comb begin
    remain_d  = remain_q;
    q_latch_d = q_latch_q;
    timer_d   = timer_q;
    judg_d    = judg_q;
    wrong_d   = wrong_q;
    p_hp_d    = p_hp_q;
    c_hp_d    = c_hp_q;
    dec_edge  = bus.DEC & ~dec_q;
    clr_edge  = bus.CLR & ~clr_q;
    entered   = (bus.STATE != state_q);
    expire    = (timer_q == TLIM - TW'(1));
    div_res   = div_prime(remain_q, bus.SEL);

    case (bus.STATE)
      ST_QUESTION: begin
        remain_d  = bus.QUESTION;
        q_latch_d = bus.QUESTION;
        timer_d   = '0;
        judg_d    = 2'b00;
        wrong_d   = 2'b00;
      end
      ST_INPUT: begin
        // A non-zero judgement freezes the round until the controller moves on.
        if (judg_q == 2'b00) begin
          if (clr_edge) begin
            remain_d = q_latch_q;
          end else if (dec_edge) begin
            if (div_res[QW]) begin
              remain_d = div_res[QW-1:0];
              wrong_d  = 2'b00;
            end else begin
              wrong_d  = 2'b11;
            end
          end
          if (timer_q < TLIM) timer_d = timer_q + TW'(1);
          judg_d = {expire, (remain_d == QW'(1))};
        end
      end
      ST_WRONG: begin
        if (entered) wrong_d = 2'b00;
      end
      ST_READY, ST_DRAW, ST_GOOD, ST_OUCH, ST_WIN, ST_LOSE: begin
        if (state_q == ST_INPUT) judg_d = 2'b00;
        if (entered && bus.STATE == ST_GOOD && c_hp_q != 3'd0) c_hp_d = c_hp_q - 3'd1;
        if (entered && bus.STATE == ST_OUCH && p_hp_q != 3'd0) p_hp_d = p_hp_q - 3'd1;
        if (bus.STATE == ST_READY && (state_q == ST_WIN || state_q == ST_LOSE)) begin
          p_hp_d = HP_RST;
          c_hp_d = HP_RST;
        end
      end
      default: ;
    endcase

    if (c_hp_d == 3'd0)      hp_out_d = 2'b01;
    else if (p_hp_d == 3'd0) hp_out_d = 2'b10;
    else                     hp_out_d = 2'b00;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= 4'b0000;
      dec_q     <= 1'b0;
      clr_q     <= 1'b0;
      remain_q  <= '0;
      q_latch_q <= '0;
      timer_q   <= '0;
      judg_q    <= 2'b00;
      wrong_q   <= 2'b00;
      hp_out_q  <= 2'b00;
      p_hp_q    <= HP_RST;
      c_hp_q    <= HP_RST;
    end else begin
      state_q   <= bus.STATE;
      dec_q     <= bus.DEC;
      clr_q     <= bus.CLR;
      remain_q  <= remain_d;
      q_latch_q <= q_latch_d;
      timer_q   <= timer_d;
      judg_q    <= judg_d;
      wrong_q   <= wrong_d;
      hp_out_q  <= hp_out_d;
      p_hp_q    <= p_hp_d;
      c_hp_q    <= c_hp_d;
    end
  end

  assign bus.JUDG_OUT  = judg_q;
  assign bus.WRONG_OUT = wrong_q;
  assign bus.HP_OUT    = hp_out_q;
  assign bus.REMAIN    = remain_q;
  assign bus.P_HP      = p_hp_q;
  assign bus.C_HP      = c_hp_q;

endmodule

// File: tb/tb_factor_judge.sv
// Bench for factor_judge: directed game rounds pinned by hand-computed values, then
// randomized rounds checked every cycle against a behavioural model of the game rules.
// Short TIME_LIMIT so that timeouts and draws occur within a few cycles.
module tb_factor_judge;
  localparam int QW = 8;
  localparam int TL = 16;

  localparam logic [3:0] READY = 4'b0010, QUES = 4'b0011, INP = 4'b0100, DRAW = 4'b0110,
                         WRNG = 4'b0111, GOOD = 4'b1000, OUCH = 4'b1001, WIN = 4'b1010,
                         LOSE = 4'b1011;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  factor_judge_if #(.QW(QW)) bus ();

  factor_judge #(.QW(QW), .TIME_LIMIT(TL), .HP_INIT(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int primes [8] = '{2, 3, 5, 7, 11, 13, 17, 19};

  // model of the game state
  int m_prev_state, m_prev_dec, m_prev_clr;
  int m_rem, m_latch, m_timer, m_judg, m_wrong, m_php, m_chp;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  function automatic bit is_known(input int s);
    return s inside {READY, QUES, INP, DRAW, WRNG, GOOD, OUCH, WIN, LOSE};
  endfunction

  // Advances the game model by one clock using the inputs present at the edge.
  task automatic model_step();
    int st, p;
    bit dec_rise, clr_rise, first;
    st = int'(bus.STATE);
    if (RST) begin
      m_prev_state = 0; m_prev_dec = 0; m_prev_clr = 0;
      m_rem = 0; m_latch = 0; m_timer = 0; m_judg = 0; m_wrong = 0;
      m_php = 3; m_chp = 3;
      return;
    end
    dec_rise = bus.DEC && m_prev_dec == 0;
    clr_rise = bus.CLR && m_prev_clr == 0;
    first    = st != m_prev_state;
    if (st == QUES) begin
      m_rem = int'(bus.QUESTION); m_latch = m_rem; m_timer = 0; m_judg = 0; m_wrong = 0;
    end else if (st == INP) begin
      if (m_judg == 0) begin
        bit expired;
        expired = (m_timer == TL - 1);
        p = primes[bus.SEL];
        if (clr_rise) m_rem = m_latch;
        else if (dec_rise) begin
          if (m_rem % p == 0) begin m_rem = m_rem / p; m_wrong = 0; end
          else m_wrong = 3;
        end
        if (m_timer < TL) m_timer++;
        m_judg = (expired ? 2 : 0) + (m_rem == 1 ? 1 : 0);
      end
    end else if (st == WRNG) begin
      if (first) m_wrong = 0;
    end else if (is_known(st)) begin
      if (m_prev_state == INP) m_judg = 0;
      if (first && st == GOOD && m_chp > 0) m_chp--;
      if (first && st == OUCH && m_php > 0) m_php--;
      if (st == READY && (m_prev_state == WIN || m_prev_state == LOSE)) begin
        m_php = 3; m_chp = 3;
      end
    end
    m_prev_state = st; m_prev_dec = bus.DEC; m_prev_clr = bus.CLR;
  endtask

  function automatic int exp_hp_out();
    if (m_chp == 0) return 1;
    if (m_php == 0) return 2;
    return 0;
  endfunction

  task automatic compare_all();
    chk("JUDG_OUT",  int'(bus.JUDG_OUT),  m_judg);
    chk("WRONG_OUT", int'(bus.WRONG_OUT), m_wrong);
    chk("HP_OUT",    int'(bus.HP_OUT),    exp_hp_out());
    chk("REMAIN",    int'(bus.REMAIN),    m_rem);
    chk("P_HP",      int'(bus.P_HP),      m_php);
    chk("C_HP",      int'(bus.C_HP),      m_chp);
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [3:0] st, input logic dec, input logic clr, input logic [2:0] sel);
    bus.STATE = st; bus.DEC = dec; bus.CLR = clr; bus.SEL = sel;
  endtask

  task automatic load_q(input int q);
    bus.QUESTION = QW'(q);
    drive(QUES, 0, 0, 0);
    tick(); tick();
  endtask

  task automatic dec_pulse(input logic [2:0] sel);
    drive(INP, 1, 0, sel); tick();
    drive(INP, 0, 0, sel); tick();
  endtask

  initial begin
    RST = 1'b1;
    bus.QUESTION = '0;
    drive(READY, 0, 0, 0);
    tick(); tick();
    chk("reset REMAIN", int'(bus.REMAIN), 0);
    chk("reset P_HP", int'(bus.P_HP), 3);
    chk("reset C_HP", int'(bus.C_HP), 3);
    chk("reset JUDG", int'(bus.JUDG_OUT), 0);
    RST = 1'b0;
    drive(READY, 0, 0, 0); tick();

    // Q=30 factored by 2,3,5
    load_q(30);
    drive(INP, 0, 0, 0); tick();
    drive(INP, 1, 0, 0); tick();
    chk("q30 /2", int'(bus.REMAIN), 15);
    drive(INP, 0, 0, 1); tick();
    drive(INP, 1, 0, 1); tick();
    chk("q30 /3", int'(bus.REMAIN), 5);
    drive(INP, 0, 0, 2); tick();
    drive(INP, 1, 0, 2); tick();
    chk("q30 /5", int'(bus.REMAIN), 1);
    chk("q30 judg", int'(bus.JUDG_OUT), 1);
    drive(GOOD, 0, 0, 0); tick(); tick(); tick();
    chk("good C_HP", int'(bus.C_HP), 2);
    chk("good judg clr", int'(bus.JUDG_OUT), 0);

    // Q=21 wrong divisor, then WRONG state holding the timer
    load_q(21);
    drive(INP, 0, 0, 0); tick();
    drive(INP, 1, 0, 0); tick();
    chk("q21 wrong", int'(bus.WRONG_OUT), 3);
    chk("q21 remain", int'(bus.REMAIN), 21);
    drive(WRNG, 0, 0, 0); repeat (20) tick();
    chk("wrong clr", int'(bus.WRONG_OUT), 0);
    chk("wrong no timeout", int'(bus.JUDG_OUT), 0);
    // 2 INPUT cycles used so far; 14 more reach the limit
    drive(INP, 0, 0, 0); repeat (13) tick();
    chk("resume pre", int'(bus.JUDG_OUT), 0);
    tick();
    chk("resume timeout", int'(bus.JUDG_OUT), 2);
    drive(OUCH, 0, 0, 0); tick(); tick();
    chk("ouch P_HP", int'(bus.P_HP), 2);

    // Plain timeout: 16 INPUT cycles without a decision
    load_q(21);
    drive(INP, 0, 0, 0); repeat (15) tick();
    chk("to pre", int'(bus.JUDG_OUT), 0);
    tick();
    chk("to judg", int'(bus.JUDG_OUT), 2);
    drive(READY, 0, 0, 0); tick();

    // Draw: final factor lands on the 16th INPUT cycle
    load_q(4);
    drive(INP, 0, 0, 0); tick();
    drive(INP, 1, 0, 0); tick();
    drive(INP, 0, 0, 0); repeat (13) tick();
    drive(INP, 1, 0, 0); tick();
    chk("draw judg", int'(bus.JUDG_OUT), 3);
    drive(DRAW, 0, 0, 0); tick(); tick();
    chk("draw P_HP", int'(bus.P_HP), 2);
    chk("draw C_HP", int'(bus.C_HP), 2);

    // CLR restores the question; CLR beats DEC
    load_q(12);
    drive(INP, 0, 0, 0); tick();
    dec_pulse(0);
    chk("clr pre", int'(bus.REMAIN), 6);
    drive(INP, 0, 1, 0); tick();
    chk("clr restore", int'(bus.REMAIN), 12);
    drive(INP, 0, 0, 0); tick();
    drive(INP, 1, 1, 1); tick();
    chk("clr+dec remain", int'(bus.REMAIN), 12);
    chk("clr+dec wrong", int'(bus.WRONG_OUT), 0);
    drive(READY, 0, 0, 0); tick();

    // Two instant wins with question 1 drain the CPU
    repeat (2) begin
      load_q(1);
      drive(INP, 0, 0, 0); tick();
      chk("q1 judg", int'(bus.JUDG_OUT), 1);
      drive(GOOD, 0, 0, 0); repeat (4) tick();
    end
    chk("cpu dead C_HP", int'(bus.C_HP), 0);
    chk("cpu dead HP_OUT", int'(bus.HP_OUT), 1);
    drive(WIN, 0, 0, 0); tick(); tick();
    drive(READY, 0, 0, 0); tick();
    chk("new game P_HP", int'(bus.P_HP), 3);
    chk("new game C_HP", int'(bus.C_HP), 3);
    chk("new game HP_OUT", int'(bus.HP_OUT), 0);

    // Reset in the middle of a round
    load_q(30);
    drive(INP, 1, 0, 0); tick();
    RST = 1'b1; tick();
    chk("midrst REMAIN", int'(bus.REMAIN), 0);
    chk("midrst C_HP", int'(bus.C_HP), 3);
    RST = 1'b0;

    // Randomized rounds
    for (int r = 0; r < 300; r++) begin
      int q, len;
      logic [3:0] fin;
      logic [3:0] ends [8];
      ends = '{GOOD, OUCH, DRAW, WIN, LOSE, READY, 4'hF, 4'h0};
      drive(READY, 0, 0, 0);
      repeat ($urandom_range(1, 2)) tick();
      q = 1;
      repeat ($urandom_range(0, 4)) begin
        int p;
        p = primes[$urandom_range(0, 4)];
        if (q * p <= 255) q = q * p;
      end
      if ($urandom_range(0, 9) == 0) q = $urandom_range(0, 255);
      bus.QUESTION = QW'(q);
      drive(QUES, 0, 0, 0);
      repeat ($urandom_range(1, 2)) tick();
      len = $urandom_range(4, 24);
      for (int c = 0; c < len; c++) begin
        drive(($urandom_range(0, 9) == 0) ? WRNG : INP, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
        RST = ($urandom_range(0, 199) == 0);
        tick();
        RST = 1'b0;
      end
      fin = ends[$urandom_range(0, 7)];
      drive(fin, 0, 0, 0);
      repeat ($urandom_range(1, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
